// File: rtl/sme_pkg.sv
// Shared types and constants for the string-match engine and its feeder.
package sme_pkg;

    localparam int unsigned STR_MAX_DEF = 32;
    localparam int unsigned PAT_MAX_DEF = 9;
    localparam int unsigned TIMEOUT_DEF = 63;

    localparam int unsigned ERR_TRUNC = 0;
    localparam int unsigned ERR_ABORT = 1;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        ACCEPT,
        DRIVE_STR,
        DRIVE_PAT,
        GAP,
        WAIT_RES,
        HOLD
    } feed_state_t;

endpackage

// File: rtl/sme_byte_buf.sv
// Byte buffer with saturating write count, sticky overflow and a sequential read pointer.
module sme_byte_buf #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          restart,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_adv,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [7:0]    rd_data,
    output logic          rd_last
);

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [CW-1:0] rd_ptr;
    logic          full;

    assign full    = (count == CW'(DEPTH));
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign rd_last = (rd_ptr == count - CW'(1));

    // Storage has no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (wr_en && (restart || !full))
            mem[restart ? AW'(0) : count[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
            rd_ptr   <= '0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
            rd_ptr   <= '0;
        end else begin
            if (wr_en) begin
                if (restart) begin
                    count    <= CW'(1);
                    overflow <= 1'b0;
                end else if (!full) begin
                    count <= count + CW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (rd_adv)
                rd_ptr <= rd_ptr + CW'(1);
        end
    end

endmodule

// File: rtl/sme_feeder.sv
// Buffers one string/pattern job, replays it to the matcher and holds the result.
module sme_feeder
    import sme_pkg::*;
#(
    parameter int unsigned STR_MAX = STR_MAX_DEF,
    parameter int unsigned PAT_MAX = PAT_MAX_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [1:0] res_err
);

    localparam int unsigned SCW = $clog2(STR_MAX + 1);
    localparam int unsigned PCW = $clog2(PAT_MAX + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    feed_state_t state_q, state_n;

    logic           in_ready_n, isstring_n, ispattern_n;
    logic [7:0]     chardata_n;
    logic           res_valid_n, res_match_n;
    logic [4:0]     res_index_n;
    logic [1:0]     res_err_n;
    logic           drv_last, drv_last_n;
    logic           str_open, str_open_n;
    logic           str_loaded, str_loaded_n;
    logic           trunc, trunc_n;
    logic [TW-1:0]  cnt, cnt_n;

    logic           str_wr, str_restart, str_adv, pat_wr, pat_adv, buf_clear;
    logic [SCW-1:0] str_cnt;
    logic [PCW-1:0] pat_cnt, pat_len_next;
    logic           str_ovf, pat_ovf, str_rd_last, pat_rd_last;
    logic [7:0]     str_rd_data, pat_rd_data;

    sme_byte_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk      (clk),
        .reset    (reset),
        .clear    (buf_clear),
        .restart  (str_restart),
        .wr_en    (str_wr),
        .wr_data  (in_data),
        .rd_adv   (str_adv),
        .count    (str_cnt),
        .overflow (str_ovf),
        .rd_data  (str_rd_data),
        .rd_last  (str_rd_last)
    );

    sme_byte_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk      (clk),
        .reset    (reset),
        .clear    (buf_clear),
        .restart  (1'b0),
        .wr_en    (pat_wr),
        .wr_data  (in_data),
        .rd_adv   (pat_adv),
        .count    (pat_cnt),
        .overflow (pat_ovf),
        .rd_data  (pat_rd_data),
        .rd_last  (pat_rd_last)
    );

    // Pattern length once the byte being accepted now has landed.
    assign pat_len_next = (pat_cnt == PCW'(PAT_MAX)) ? pat_cnt : pat_cnt + PCW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ACCEPT;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n      = state_q;
        isstring_n   = 1'b0;
        ispattern_n  = 1'b0;
        chardata_n   = 8'h00;
        res_valid_n  = res_valid;
        res_match_n  = res_match;
        res_index_n  = res_index;
        res_err_n    = res_err;
        drv_last_n   = drv_last;
        str_open_n   = str_open;
        str_loaded_n = str_loaded;
        cnt_n        = cnt;
        trunc_n      = trunc | str_ovf | pat_ovf;
        str_wr       = 1'b0;
        str_restart  = 1'b0;
        str_adv      = 1'b0;
        pat_wr       = 1'b0;
        pat_adv      = 1'b0;
        buf_clear    = 1'b0;

        unique case (state_q)
            ACCEPT: begin
                if (in_valid && !in_kind) begin
                    str_wr      = 1'b1;
                    str_restart = !str_open;
                    str_open_n  = !in_last;
                end else if (in_valid) begin
                    pat_wr = 1'b1;
                    if (in_last) begin
                        if (str_cnt != '0) begin
                            state_n      = DRIVE_STR;
                            isstring_n   = 1'b1;
                            chardata_n   = str_rd_data;
                            drv_last_n   = str_rd_last;
                            str_adv      = 1'b1;
                            str_loaded_n = 1'b1;
                        end else if (str_loaded) begin
                            // pat[0] may be the byte arriving this cycle, so bypass it.
                            state_n     = DRIVE_PAT;
                            ispattern_n = 1'b1;
                            chardata_n  = (pat_cnt == '0) ? in_data : pat_rd_data;
                            drv_last_n  = (pat_len_next == PCW'(1));
                            pat_adv     = 1'b1;
                        end else begin
                            state_n                = HOLD;
                            res_valid_n            = 1'b1;
                            res_match_n            = 1'b0;
                            res_index_n            = 5'd0;
                            res_err_n              = 2'b00;
                            res_err_n[ERR_ABORT]   = 1'b1;
                        end
                    end
                end
            end
            DRIVE_STR: begin
                if (drv_last) begin
                    state_n     = DRIVE_PAT;
                    ispattern_n = 1'b1;
                    chardata_n  = pat_rd_data;
                    drv_last_n  = pat_rd_last;
                    pat_adv     = 1'b1;
                end else begin
                    isstring_n = 1'b1;
                    chardata_n = str_rd_data;
                    drv_last_n = str_rd_last;
                    str_adv    = 1'b1;
                end
            end
            DRIVE_PAT: begin
                if (drv_last) begin
                    state_n = GAP;
                end else begin
                    ispattern_n = 1'b1;
                    chardata_n  = pat_rd_data;
                    drv_last_n  = pat_rd_last;
                    pat_adv     = 1'b1;
                end
            end
            GAP: begin
                state_n = WAIT_RES;
                cnt_n   = '0;
            end
            WAIT_RES: begin
                cnt_n = cnt + TW'(1);
                if (sme_valid) begin
                    state_n              = HOLD;
                    res_valid_n          = 1'b1;
                    res_match_n          = sme_match;
                    res_index_n          = sme_index;
                    res_err_n            = 2'b00;
                    res_err_n[ERR_TRUNC] = trunc;
                end else if (cnt + TW'(1) == TW'(TIMEOUT)) begin
                    state_n              = HOLD;
                    res_valid_n          = 1'b1;
                    res_match_n          = 1'b0;
                    res_index_n          = 5'd0;
                    res_err_n            = 2'b00;
                    res_err_n[ERR_ABORT] = 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_n     = ACCEPT;
                    res_valid_n = 1'b0;
                    buf_clear   = 1'b1;
                    str_open_n  = 1'b0;
                    trunc_n     = 1'b0;
                    cnt_n       = '0;
                end
            end
            default: state_n = ACCEPT;
        endcase

        in_ready_n = (state_n == ACCEPT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready   <= 1'b1;
            chardata   <= 8'h00;
            isstring   <= 1'b0;
            ispattern  <= 1'b0;
            res_valid  <= 1'b0;
            res_match  <= 1'b0;
            res_index  <= 5'd0;
            res_err    <= 2'b00;
            drv_last   <= 1'b0;
            str_open   <= 1'b0;
            str_loaded <= 1'b0;
            trunc      <= 1'b0;
            cnt        <= '0;
        end else begin
            in_ready   <= in_ready_n;
            chardata   <= chardata_n;
            isstring   <= isstring_n;
            ispattern  <= ispattern_n;
            res_valid  <= res_valid_n;
            res_match  <= res_match_n;
            res_index  <= res_index_n;
            res_err    <= res_err_n;
            drv_last   <= drv_last_n;
            str_open   <= str_open_n;
            str_loaded <= str_loaded_n;
            trunc      <= trunc_n;
            cnt        <= cnt_n;
        end
    end

endmodule

// File: tb/tb_sme_feeder.sv
// Randomized self-checking bench for sme_feeder against a job-level reference model.
module tb_sme_feeder;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 9;
    localparam int TIMEOUT = 63;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_kind, in_last;
    logic [7:0] in_data, chardata;
    logic       isstring, ispattern;
    logic       sme_valid, sme_match;
    logic [4:0] sme_index;
    logic       res_valid, res_ready, res_match;
    logic [4:0] res_index;
    logic [1:0] res_err;

    always #5 clk = ~clk;

    sme_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_kind   (in_kind),
        .in_last   (in_last),
        .chardata  (chardata),
        .isstring  (isstring),
        .ispattern (ispattern),
        .sme_valid (sme_valid),
        .sme_match (sme_match),
        .sme_index (sme_index),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_match (res_match),
        .res_index (res_index),
        .res_err   (res_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic       kind;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t job_q[$];
    bit    m_loaded = 1'b0;

    task automatic add_text(input logic kind, input string s);
        beat_t b;
        for (int i = 0; i < s.len(); i++) begin
            b.kind = kind;
            b.last = (i == s.len() - 1);
            b.data = 8'(s[i]);
            job_q.push_back(b);
        end
    endtask

    task automatic add_rand(input logic kind, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.kind = kind;
            b.last = (i == len - 1);
            b.data = 8'($urandom);
            job_q.push_back(b);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_job();
        bit acc;
        int guard;
        foreach (job_q[i]) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) next_cycle();
            in_valid = 1'b1;
            in_kind  = job_q[i].kind;
            in_last  = job_q[i].last;
            in_data  = job_q[i].data;
            guard = 0;
            do begin
                acc = in_ready;
                next_cycle();
                guard++;
            end while (!acc && guard < 50);
            if (!acc) check("accept_bound", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // stub_d < 0: matcher never answers; otherwise pulse sme_valid stub_d cycles after the GAP cycle.
    task automatic run_job(input int stub_d, input int hold, input logic smatch, input logic [4:0] sidx);
        logic [7:0] cur[$], lstr[$], pat[$];
        logic [8:0] exp_q[$], obs_q[$];
        bit         has_str = 0, trunc = 0, driven, got = 0;
        logic       e_match;
        logic [4:0] e_index;
        logic [1:0] e_err;
        int         exp_lat, res_t = -1, t = 0, gap_t = -1, first_t = -1;
        int         zero_bad = 0, reopen_bad = 0, bad = 0, ok;
        logic       h_match;
        logic [4:0] h_index;
        logic [1:0] h_err;

        foreach (job_q[i]) begin
            if (!job_q[i].kind) begin
                cur.push_back(job_q[i].data);
                if (job_q[i].last) begin
                    lstr = cur;
                    has_str = 1;
                    if (cur.size() > STR_MAX) trunc = 1;
                    cur.delete();
                end
            end else begin
                pat.push_back(job_q[i].data);
                if (job_q[i].last && pat.size() > PAT_MAX) trunc = 1;
            end
        end
        if (has_str)
            for (int i = 0; i < lstr.size() && i < STR_MAX; i++) exp_q.push_back({1'b0, lstr[i]});
        driven = has_str || m_loaded;
        if (driven)
            for (int i = 0; i < pat.size() && i < PAT_MAX; i++) exp_q.push_back({1'b1, pat[i]});
        m_loaded = m_loaded || has_str;

        if (!driven || stub_d < 0) begin
            e_match = 1'b0; e_index = 5'd0; e_err = 2'b10;
        end else begin
            e_match = smatch; e_index = sidx; e_err = {1'b0, trunc};
        end
        exp_lat = !driven ? 0 : exp_q.size() + ((stub_d < 0) ? TIMEOUT : stub_d) + 1;

        drive_job();

        while (t < 300) begin
            if (res_valid) begin
                got = 1; res_t = t;
                break;
            end
            if (isstring || ispattern) begin
                if (gap_t >= 0 || (isstring && ispattern)) reopen_bad++;
                if (first_t < 0) first_t = t;
                obs_q.push_back({ispattern, chardata});
            end else begin
                if (chardata != 8'h00) zero_bad++;
                if (first_t >= 0 && gap_t < 0) gap_t = t;
            end
            if (gap_t >= 0 && stub_d >= 0 && t == gap_t + stub_d) begin
                sme_valid = 1'b1; sme_match = smatch; sme_index = sidx;
            end else begin
                sme_valid = 1'b0; sme_match = 1'($urandom); sme_index = 5'($urandom);
            end
            next_cycle();
            t++;
        end
        sme_valid = 1'b0;

        check("strobe_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        check("strobe_bytes", bad, 0);
        if (exp_q.size() > 0) check("first_strobe_t", first_t, 0);
        check("idle_chardata_zero", zero_bad, 0);
        check("strobe_contiguous", reopen_bad, 0);
        check("res_valid_seen", got, 1);
        check("res_latency", res_t, exp_lat);
        check("res_match", res_match, e_match);
        check("res_index", res_index, e_index);
        check("res_err", res_err, e_err);

        if (hold > 0) begin
            ok = 1;
            h_match = res_match; h_index = res_index; h_err = res_err;
            repeat (hold) begin
                next_cycle();
                if (!res_valid || in_ready || res_match !== h_match ||
                    res_index !== h_index || res_err !== h_err) ok = 0;
            end
            check("hold_stable", ok, 1);
        end
        res_ready = 1'b1;
        next_cycle();
        res_ready = 1'b0;
        check("res_valid_clear", res_valid, 1'b0);
        check("in_ready_back", in_ready, 1'b1);
        job_q.delete();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_kind = 1'b0; in_last = 1'b0; in_data = 8'h00;
        sme_valid = 1'b0; sme_match = 1'b0; sme_index = 5'd0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_strobes", {isstring, ispattern, chardata}, 10'd0);
        check("rst_result", {res_valid, res_match, res_index, res_err}, 9'd0);
        reset = 1'b0;
        next_cycle();

        // Stray matcher pulse while idle must not produce a result.
        sme_valid = 1'b1;
        next_cycle();
        sme_valid = 1'b0;
        next_cycle();
        check("stray_sme_valid", res_valid, 1'b0);

        // No string loaded since reset.
        add_text(1'b1, "ab");
        run_job(3, 0, 1'b1, 5'd7);

        // Basic job.
        add_text(1'b0, "ab cd");
        add_text(1'b1, "cd");
        run_job(4, 0, 1'b1, 5'd3);

        // String reuse.
        add_text(1'b1, "ab");
        run_job($urandom_range(1, 8), 0, 1'b0, 5'($urandom));

        // Overflow on both fields.
        add_rand(1'b0, 40);
        add_rand(1'b1, 12);
        run_job(2, 0, 1'b1, 5'd31);

        // Timeout.
        add_rand(1'b0, 6);
        add_rand(1'b1, 3);
        run_job(-1, 0, 1'b1, 5'd5);

        // Backpressure, with two string fields where the last one wins.
        add_rand(1'b0, 7);
        add_rand(1'b0, 4);
        add_rand(1'b1, 5);
        run_job(5, 10, 1'b1, 5'd9);

        // Random mix.
        for (int j = 0; j < 8; j++) begin
            repeat ($urandom_range(0, 2)) add_rand(1'b0, $urandom_range(1, 40));
            add_rand(1'b1, $urandom_range(1, 12));
            run_job($urandom_range(1, 8), $urandom_range(0, 3), 1'($urandom), 5'($urandom));
        end

        // Reset during DRIVE_STR aborts and forgets the loaded string.
        add_rand(1'b0, 20);
        add_rand(1'b1, 3);
        drive_job();
        job_q.delete();
        next_cycle();
        next_cycle();
        check("pre_reset_isstring", isstring, 1'b1);
        reset = 1'b1;
        #1;
        check("reset_strobes_drop", {isstring, ispattern, chardata}, 10'd0);
        check("reset_in_ready", in_ready, 1'b1);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        m_loaded = 1'b0;
        add_text(1'b1, "xyz");
        run_job(2, 0, 1'b1, 5'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sme_feeder.md
# sme_feeder

Upstream companion of the string-match engine. Accepts a byte stream of string and pattern fields over a valid/ready handshake, buffers one job, and replays it to the matcher with the `chardata`/`isstring`/`ispattern` strobe protocol. It then waits for the matcher's one-cycle `valid` pulse and holds the result in a single-entry output register with its own valid/ready handshake. It also adds truncation and timeout detection, which the matcher lacks.

## Interface
- `STR_MAX`, default 32: string buffer depth in bytes.
- `PAT_MAX`, default 9: pattern buffer depth in bytes.
- `TIMEOUT`, default 63: maximum cycles in WAIT_RES before the job is aborted.

Ports (reset is asynchronous, active-high; clock is `clk`):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input byte offered.
- `in_ready` out 1: feeder accepts the byte this cycle.
- `in_data` in 8: byte.
- `in_kind` in 1: 0 = string field, 1 = pattern field.
- `in_last` in 1: last byte of the current field.
- `chardata` out 8: byte to matcher.
- `isstring` out 1: string strobe to matcher.
- `ispattern` out 1: pattern strobe to matcher.
- `sme_valid` in 1: matcher result pulse.
- `sme_match` in 1: matcher match flag.
- `sme_index` in 5: matcher match index.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes the result.
- `res_match` out 1: match flag.
- `res_index` out 5: match index.
- `res_err` out 2: bit0 = field truncated; bit1 = timeout or no string loaded.

## Operation
- States: ACCEPT, DRIVE_STR, DRIVE_PAT, GAP, WAIT_RES, HOLD.
- **ACCEPT**
  - `in_ready` = 1 only in ACCEPT.
  - A job is zero or more string fields followed by exactly one pattern field. A later string field in the same job restarts the string write count, so the last string wins.
  - Bytes beyond `STR_MAX`/`PAT_MAX` are dropped and set sticky `trunc`. Stored length saturates at the maximum.
  - Accepting a pattern byte with `in_last` = 1 ends the job:
    - Go to DRIVE_STR if a string field arrived in this job.
    - Otherwise go to DRIVE_PAT if a string has been sent since reset.
    - Otherwise go to HOLD with `res_err[1]` = 1 and `res_match` = 0; the matcher is not driven.
- **DRIVE_STR**: `isstring` = 1 and `chardata` = str[k] for k = 0..len-1 on consecutive cycles, then DRIVE_PAT.
- **DRIVE_PAT**: `ispattern` = 1 for pat[0..plen-1] on consecutive cycles, immediately after the string bytes with no gap. Then GAP.
- **GAP**: one cycle with both strobes low, then WAIT_RES.
- **WAIT_RES**
  - Strobes low; timeout counter increments each cycle.
  - `sme_valid` = 1: capture `sme_match` and `sme_index`, set `res_err[0]` = `trunc`, go to HOLD.
  - Counter reaches `TIMEOUT`: go to HOLD with match 0, index 0, `res_err[1]` = 1.
  - `sme_valid` outside WAIT_RES is ignored.
- **HOLD**: `res_valid` = 1. When `res_valid && res_ready`, clear `res_valid`, `trunc`, lengths and counter, and go to ACCEPT.
- Strobes are registered outputs. `chardata` = 0 whenever both strobes are low.
- Every last string is retained across jobs. When a job has no new string, the matcher reuses its stored string.

## Timing
- Reset values:
  - state = ACCEPT; `in_ready` = 1.
  - `chardata`, `isstring`, `ispattern` = 0.
  - `res_valid`, `res_match`, `res_index`, `res_err` = 0.
  - `str_loaded` = 0; lengths and counters = 0.
- Reset mid-job aborts immediately. Buffer contents are don't-care, but `str_loaded` = 0.
- First strobe is high on the cycle after the accepting edge of the final pattern byte.
- Drive phase lasts slen + plen cycles, followed by 1 GAP cycle.
- `res_valid` rises the cycle after the `sme_valid` edge, or after the `TIMEOUT`-th WAIT_RES cycle.
- `res_valid` holds and data is stable until accepted.
- `in_ready` returns to 1 the cycle after the result handshake. No input is accepted during the drive, wait or hold phases.
- `sme_valid` arriving on the same cycle the counter hits `TIMEOUT`: the result wins and no error is flagged.
- Index width: 5 bits, passed through unchanged.

## Structure
- Package `sme_pkg`:
  - `STR_MAX` and `PAT_MAX` defaults.
  - State enum `feed_state_t`.
  - Error bit positions `ERR_TRUNC` = 0 and `ERR_ABORT` = 1.
  - Character constants `CH_CARET` = 8'h5E, `CH_DOT` = 8'h2E, `CH_DOLLAR` = 8'h24, `CH_SPACE` = 8'h20, shared with the matcher.
- Sub-module `sme_byte_buf` (parameter DEPTH):
  - Saturating write counter with overflow flag.
  - Restart input.
  - Read pointer with `rd_last`.
  - Instantiated twice: string and pattern.

## Test plan
- **Basic job:** string "ab cd" then pattern "cd" (no stalls); stub returns match=1, index=3 after 4 cycles. Expect:
  - `isstring` high for exactly 5 cycles, then `ispattern` for 2 cycles, then 1 GAP cycle.
  - `res_valid` with match=1, index=3, err=0.
- **String reuse:** second job with pattern "ab" only. Expect no `isstring` cycles, `ispattern` for 2 cycles, and the stub result passed through.
- **Overflow:** 40-byte string and 12-byte pattern. Expect:
  - 32 `isstring` cycles and 9 `ispattern` cycles.
  - `res_err[0]` = 1.
- **No string after reset:** pattern-only job. Expect:
  - Strobes never rise.
  - `res_valid` with err=2'b10 and match=0.
- **Timeout:** stub never pulses `sme_valid`. Expect `res_valid` with err bit1 = 1 exactly 63 WAIT_RES cycles after GAP.
- **Backpressure and reset:**
  - Hold `res_ready` = 0 for 10 cycles: result stable, `in_ready` = 0.
  - Assert `reset` during DRIVE_STR: strobes drop immediately and state returns to ACCEPT.
